// File: rtl/dotprod_operand_feeder_if.sv
// Stream and operand-bus bundle for dotprod_operand_feeder.
// slave  : the feeder's view (consumes element pairs, produces vectors and results).
// master : the surrounding environment (sequencer, dot-product array, result sink).
// The in_last wire exists only when DOTFEED_ZEROPAD_EN is defined.
interface dotprod_operand_feeder_if #(
  parameter int N   = 32,
  parameter int LEN = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0]          in_a;
  logic [N-1:0]          in_b;
`ifdef DOTFEED_ZEROPAD_EN
  logic                  in_last;
`endif
  logic [LEN-1:0][N-1:0] vec_a;
  logic [LEN-1:0][N-1:0] vec_b;
  logic [N-1:0]          dp_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [N-1:0]          out_data;

`ifdef DOTFEED_ZEROPAD_EN
  modport slave (
    input  in_valid, in_a, in_b, in_last, dp_result, out_ready,
    output in_ready, vec_a, vec_b, out_valid, out_data
  );
  modport master (
    output in_valid, in_a, in_b, in_last, dp_result, out_ready,
    input  in_ready, vec_a, vec_b, out_valid, out_data
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, dp_result, out_ready,
    output in_ready, vec_a, vec_b, out_valid, out_data
  );
  modport master (
    output in_valid, in_a, in_b, dp_result, out_ready,
    input  in_ready, vec_a, vec_b, out_valid, out_data
  );
`endif
endinterface

// File: rtl/dotprod_operand_feeder.sv
// Operand feeder for a combinational dot-product array.
// Collects LEN element pairs from a valid/ready stream into vec_a/vec_b, holds the
// vectors stable for DP_LAT cycles, captures dp_result and offers it on a
// valid/ready output stream. in_ready is registered and depends on state only.
// Optional feature macro: DOTFEED_ZEROPAD_EN (in_last ends a short vector early and
// zero-fills the remaining lanes).
module dotprod_operand_feeder #(
  parameter int N      = 32,
  parameter int LEN    = 4,
  parameter int DP_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  dotprod_operand_feeder_if.slave bus
);

  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int CNT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DP_LAT - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e                state_q,     state_d;
  logic [IDX_W-1:0]      idx_q,       idx_d;
  logic [CNT_W-1:0]      wait_cnt_q,  wait_cnt_d;
  logic [LEN-1:0][N-1:0] vec_a_q,     vec_a_d;
  logic [LEN-1:0][N-1:0] vec_b_q,     vec_b_d;
  logic [N-1:0]          out_data_q,  out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q,  in_ready_d;

  logic accept;
  logic final_beat;

  // Next-state and datapath: fill lanes, count the array latency, hold the result.
  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a signal unassigned (no latch).
    state_d    = state_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    vec_a_d    = vec_a_q;
    vec_b_d    = vec_b_q;
    out_data_d = out_data_q;
    final_beat = 1'b0;
    accept     = bus.in_valid && in_ready_q;

    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          vec_a_d[idx_q] = bus.in_a;
          vec_b_d[idx_q] = bus.in_b;
          final_beat     = (idx_q == IDX_LAST);
`ifdef DOTFEED_ZEROPAD_EN
          // A short vector clears the lanes above the current one in the same edge.
          if (bus.in_last && !final_beat) begin
            for (int i = 0; i < LEN; i++) begin
              if (i > int'(idx_q)) begin
                vec_a_d[i] = '0;
                vec_b_d[i] = '0;
              end
            end
            final_beat = 1'b1;
          end
`endif
          if (final_beat) begin
            idx_d      = '0;
            wait_cnt_d = '0;
            state_d    = S_WAIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == CNT_LAST) begin
          out_data_d = bus.dp_result;
          state_d    = S_HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase

    // Handshake flags are registered copies of the next state, never of out_ready.
    out_valid_d = (state_d == S_HOLD);
    in_ready_d  = (state_d == S_FILL);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= S_FILL;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
      // NOTE: the operand vectors are reset too, because they drive the array directly.
      vec_a_q     <= '0;
      vec_b_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_cnt_q  <= wait_cnt_d;
      vec_a_q     <= vec_a_d;
      vec_b_q     <= vec_b_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.vec_a     = vec_a_q;
  assign bus.vec_b     = vec_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
